sa_ctrl: RTL and testbench
==========================

SA_CTRL -- requirements
Module: sa_ctrl

Interface
REQ-001 Parameter PE_SIZE, default 16, array rows/columns sequenced.
REQ-002 Parameter LEN_WIDTH, default 8, width of the vector-count field.
REQ-003 Parameter CNT_WIDTH, default 10, phase-counter width; SHALL be at least bits(2^LEN_WIDTH + 2*PE_SIZE).
REQ-004 clk  input  1  the single clock; all state updates on its rising edge.
REQ-005 rst_n  input  1  reset, asynchronous and active-low.
REQ-006 start_i  input  1  one-cycle request to run one tile.
REQ-007 clear_i  input  1  synchronous abort back to IDLE.
REQ-008 len_i  input  LEN_WIDTH  weight vectors to stream (N); sampled on accepted start.
REQ-009 ready_o  output  1  high only in IDLE.
REQ-010 busy_o  output  1  high in PRELOAD, COMPUTE and DRAIN.
REQ-011 done_o  output  1  one-cycle pulse at tile completion.
REQ-012 ifmap_rd_en_o  output  1  ifmap buffer read strobe.
REQ-013 ifmap_addr_o  output  CNT_WIDTH  ifmap buffer row address.
REQ-014 weight_rd_en_o  output  1  weight buffer read strobe.
REQ-015 weight_addr_o  output  CNT_WIDTH  weight buffer vector address.
REQ-016 ifmap_en_row_o  output  PE_SIZE  array ifmap enables.
REQ-017 weight_en_col_o  output  PE_SIZE  skewed array weight enables.
REQ-018 psum_en_row_o  output  PE_SIZE  skewed array psum-injection enables.

Function
REQ-019 FSM states: IDLE, PRELOAD, COMPUTE, DRAIN, DONE; all outputs registered.
- cnt = phase counter, zeroed on every state entry.
REQ-020 IDLE -> PRELOAD on an edge with start_i=1, clear_i=0 and len_i!=0; len_i is latched as N on that edge.
- start_i with len_i=0 is ignored.
- start_i outside IDLE is ignored.
REQ-021 PRELOAD lasts PE_SIZE cycles.
- ifmap_rd_en_o=1, ifmap_addr_o=cnt (0..PE_SIZE-1).
- ifmap_en_row_o all ones.
- Then -> COMPUTE.
REQ-022 COMPUTE lasts N+PE_SIZE-1 cycles.
- weight_rd_en_o=1 and weight_addr_o=cnt for cnt<N; otherwise weight_rd_en_o=0 and weight_addr_o holds N-1.
- weight_en_col_o[k]=1 iff k<=cnt<k+N; psum_en_row_o[k] identical.
- ifmap_en_row_o all zeros.
REQ-023 DRAIN lasts PE_SIZE cycles with all enables and strobes zero, then -> DONE.
REQ-024 DONE lasts exactly one cycle with done_o=1, then -> IDLE.
REQ-025 clear_i=1 in any state forces IDLE on the next edge with all enables and strobes zero and no done_o; clear_i wins over start_i in the same cycle.
REQ-026 Outside their active phases, enables, strobes and addresses are zero, except weight_addr_o per REQ-022.
REQ-027 Counter comparisons SHALL be unsigned with no wrap; N=2^LEN_WIDTH-1 SHALL complete correctly.

Reset
REQ-028 While rst_n=0: state IDLE, cnt=0, N=0, ready_o=1, all other outputs 0.
REQ-029 The first start_i is accepted on the first rising edge after rst_n deasserts.
REQ-030 rst_n asserted mid-tile SHALL behave as REQ-028 immediately, with no done_o.

Verification (PE_SIZE=16, edge E0 accepts start)
REQ-031 start_i=1, len_i=16 at E0.
- PRELOAD cycles 1-16, with ifmap_addr_o 0..15.
- COMPUTE cycles 17-47.
- DRAIN cycles 48-63.
- done_o=1 at cycle 64 only; ready_o=1 at cycle 65.
REQ-032 Same run, skew check:
- weight_en_col_o[0]=1 in cycles 17-32.
- weight_en_col_o[15]=1 in cycles 32-47.
- psum_en_row_o equals weight_en_col_o every cycle.
REQ-033 len_i=1:
- COMPUTE 16 cycles, weight_addr_o=0.
- Exactly one enable bit set per cycle, walking bit 0..15.
- done_o at cycle 49.
REQ-034 Ignored requests:
- start_i with len_i=0 -> ready_o stays 1, all outputs stay 0.
- start_i during COMPUTE -> timing unchanged.
- start_i with clear_i together in IDLE -> stays IDLE.
REQ-035 clear_i at cycle 20 -> from cycle 21 IDLE, all enables 0, ready_o=1, no done_o; a new start then runs a full tile.
REQ-036 rst_n=0 asynchronously at cycle 30 -> outputs zero and ready_o=1 before the next edge; no done_o.

Source files
------------

// File: rtl/sa_ctrl_if.sv
// sa_ctrl_if -- request/status and buffer/array control bundle for sa_ctrl.
//   master: drives start_i, clear_i, len_i; observes everything else.
//   slave : the sequencer; consumes the requests and drives status,
//           buffer read strobes/addresses and the array enable vectors.
interface sa_ctrl_if #(
  parameter int PE_SIZE   = 16,
  parameter int LEN_WIDTH = 8,
  parameter int CNT_WIDTH = 10
);
  logic                 start_i;
  logic                 clear_i;
  logic [LEN_WIDTH-1:0] len_i;
  logic                 ready_o;
  logic                 busy_o;
  logic                 done_o;
  logic                 ifmap_rd_en_o;
  logic [CNT_WIDTH-1:0] ifmap_addr_o;
  logic                 weight_rd_en_o;
  logic [CNT_WIDTH-1:0] weight_addr_o;
  logic [PE_SIZE-1:0]   ifmap_en_row_o;
  logic [PE_SIZE-1:0]   weight_en_col_o;
  logic [PE_SIZE-1:0]   psum_en_row_o;

  modport master (
    output start_i, clear_i, len_i,
    input  ready_o, busy_o, done_o, ifmap_rd_en_o, ifmap_addr_o,
           weight_rd_en_o, weight_addr_o, ifmap_en_row_o,
           weight_en_col_o, psum_en_row_o
  );

  modport slave (
    input  start_i, clear_i, len_i,
    output ready_o, busy_o, done_o, ifmap_rd_en_o, ifmap_addr_o,
           weight_rd_en_o, weight_addr_o, ifmap_en_row_o,
           weight_en_col_o, psum_en_row_o
  );
endinterface

// File: rtl/sa_ctrl.sv
// sa_ctrl -- tile sequencer for a PE_SIZE x PE_SIZE systolic array.
//   clk   : single clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : sa_ctrl_if.slave -- start/clear/len requests in; ready/busy/done
//           status, ifmap/weight buffer read strobes and addresses, and the
//           row/column enable vectors out.
// A tile runs PRELOAD (PE_SIZE cycles of ifmap rows), COMPUTE (N weight
// vectors plus PE_SIZE-1 skew cycles), DRAIN (PE_SIZE cycles), DONE (1 cycle).
// Every output is registered: its next value is derived from the next state
// and next counter, so an output in a cycle reflects that cycle's phase.
module sa_ctrl #(
  parameter int PE_SIZE   = 16,
  parameter int LEN_WIDTH = 8,
  parameter int CNT_WIDTH = 10
) (
  input  logic      clk,
  input  logic      rst_n,
  sa_ctrl_if.slave  bus
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_PRELOAD = 3'd1;
  localparam logic [2:0] S_COMPUTE = 3'd2;
  localparam logic [2:0] S_DRAIN   = 3'd3;
  localparam logic [2:0] S_DONE    = 3'd4;

  localparam logic [CNT_WIDTH-1:0] PE_LAST = CNT_WIDTH'(PE_SIZE - 1);

  logic [2:0]           state_q, state_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic [LEN_WIDTH-1:0] n_q, n_d;
  logic [CNT_WIDTH-1:0] n_ext_q, n_ext_d;

  logic                 ready_q, ready_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 ifmap_rd_en_q, ifmap_rd_en_d;
  logic [CNT_WIDTH-1:0] ifmap_addr_q, ifmap_addr_d;
  logic                 weight_rd_en_q, weight_rd_en_d;
  logic [CNT_WIDTH-1:0] weight_addr_q, weight_addr_d;
  logic [PE_SIZE-1:0]   ifmap_en_row_q, ifmap_en_row_d;
  logic [PE_SIZE-1:0]   skew_en_q, skew_en_d;

  // Zero-extend N so all counter comparisons are unsigned and wrap-free.
  assign n_ext_q = CNT_WIDTH'(n_q);
  assign n_ext_d = CNT_WIDTH'(n_d);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 1'b1;
    n_d     = n_q;
    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (bus.start_i && (bus.len_i != '0)) begin
          state_d = S_PRELOAD;
          n_d     = bus.len_i;
        end
      end
      S_PRELOAD: begin
        if (cnt_q == PE_LAST) begin
          state_d = S_COMPUTE;
          cnt_d   = '0;
        end
      end
      S_COMPUTE: begin
        // Last cycle is cnt = N + PE_SIZE - 2; N >= 1 so this never underflows.
        if (cnt_q == n_ext_q + PE_LAST - 1'b1) begin
          state_d = S_DRAIN;
          cnt_d   = '0;
        end
      end
      S_DRAIN: begin
        if (cnt_q == PE_LAST) begin
          state_d = S_DONE;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
    // Abort has priority over everything, including a same-cycle start.
    if (bus.clear_i) begin
      state_d = S_IDLE;
      cnt_d   = '0;
    end
  end

  always_comb begin
    ready_d        = (state_d == S_IDLE);
    busy_d         = (state_d == S_PRELOAD) || (state_d == S_COMPUTE) ||
                     (state_d == S_DRAIN);
    done_d         = (state_d == S_DONE);
    ifmap_rd_en_d  = (state_d == S_PRELOAD);
    ifmap_addr_d   = (state_d == S_PRELOAD) ? cnt_d : '0;
    ifmap_en_row_d = {PE_SIZE{state_d == S_PRELOAD}};
    weight_rd_en_d = 1'b0;
    weight_addr_d  = '0;
    if (state_d == S_COMPUTE) begin
      if (cnt_d < n_ext_d) begin
        weight_rd_en_d = 1'b1;
        weight_addr_d  = cnt_d;
      end else begin
        weight_addr_d  = n_ext_d - 1'b1;
      end
    end
  end

  // Column k sees weight vectors during cnt in [k, k+N): a diagonal skew.
  genvar gi;
  generate
    for (gi = 0; gi < PE_SIZE; gi++) begin : g_skew
      assign skew_en_d[gi] = (state_d == S_COMPUTE) &&
                             (cnt_d >= CNT_WIDTH'(gi)) &&
                             (cnt_d < CNT_WIDTH'(gi) + n_ext_d);
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= S_IDLE;
      cnt_q          <= '0;
      n_q            <= '0;
      ready_q        <= 1'b1;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
      ifmap_rd_en_q  <= 1'b0;
      ifmap_addr_q   <= '0;
      weight_rd_en_q <= 1'b0;
      weight_addr_q  <= '0;
      ifmap_en_row_q <= '0;
      skew_en_q      <= '0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      n_q            <= n_d;
      ready_q        <= ready_d;
      busy_q         <= busy_d;
      done_q         <= done_d;
      ifmap_rd_en_q  <= ifmap_rd_en_d;
      ifmap_addr_q   <= ifmap_addr_d;
      weight_rd_en_q <= weight_rd_en_d;
      weight_addr_q  <= weight_addr_d;
      ifmap_en_row_q <= ifmap_en_row_d;
      skew_en_q      <= skew_en_d;
    end
  end

  assign bus.ready_o         = ready_q;
  assign bus.busy_o          = busy_q;
  assign bus.done_o          = done_q;
  assign bus.ifmap_rd_en_o   = ifmap_rd_en_q;
  assign bus.ifmap_addr_o    = ifmap_addr_q;
  assign bus.weight_rd_en_o  = weight_rd_en_q;
  assign bus.weight_addr_o   = weight_addr_q;
  assign bus.ifmap_en_row_o  = ifmap_en_row_q;
  // Psum injection follows exactly the same diagonal as the weight enables.
  assign bus.weight_en_col_o = skew_en_q;
  assign bus.psum_en_row_o   = skew_en_q;

endmodule

// File: tb/tb_sa_ctrl.sv
// tb_sa_ctrl -- directed bench for sa_ctrl (PE_SIZE=16, LEN_WIDTH=8,
// CNT_WIDTH=10). Outputs are sampled on the falling edge; cycle 1 is the
// first falling edge after the accepting rising edge E0.
module tb_sa_ctrl;
  localparam int PE = 16;
  localparam int LW = 8;
  localparam int CW = 10;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_checks = 0;
  int   n_errors = 0;

  always #5 clk = ~clk;

  sa_ctrl_if #(.PE_SIZE(PE), .LEN_WIDTH(LW), .CNT_WIDTH(CW)) bus ();

  sa_ctrl #(.PE_SIZE(PE), .LEN_WIDTH(LW), .CNT_WIDTH(CW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_idle(input string tag);
    check({tag, " ready"}, 32'(bus.ready_o), 32'd1);
    check({tag, " busy"},  32'(bus.busy_o),  32'd0);
    check({tag, " done"},  32'(bus.done_o),  32'd0);
    check({tag, " strobes"},
          32'({bus.ifmap_rd_en_o, bus.weight_rd_en_o}), 32'd0);
    check({tag, " addrs"}, 32'({bus.ifmap_addr_o, bus.weight_addr_o}), 32'd0);
    check({tag, " enables"},
          32'(bus.ifmap_en_row_o | bus.weight_en_col_o | bus.psum_en_row_o),
          32'd0);
  endtask

  // Expected outputs in cycle c of a tile of length L, straight from the
  // phase timeline: PRELOAD 1..16, COMPUTE 17..L+31, DRAIN next 16, DONE 1.
  task automatic check_cycle(input int c, input int L);
    logic        e_ready, e_busy, e_done, e_ird, e_wrd;
    logic [31:0] e_iaddr, e_waddr;
    logic [15:0] e_row, e_col;
    int          cend, dend, cnt;
    string       t;
    e_ready = 0; e_busy = 0; e_done = 0; e_ird = 0; e_wrd = 0;
    e_iaddr = 0; e_waddr = 0; e_row = 0; e_col = 0;
    cend = PE + L + PE - 1;
    dend = cend + PE;
    if (c <= PE) begin
      e_busy = 1; e_ird = 1; e_iaddr = 32'(c - 1); e_row = 16'hFFFF;
    end else if (c <= cend) begin
      e_busy = 1;
      cnt = c - PE - 1;
      if (cnt < L) begin
        e_wrd = 1; e_waddr = 32'(cnt);
      end else begin
        e_waddr = 32'(L - 1);
      end
      for (int k = 0; k < PE; k++) e_col[k] = (k <= cnt) && (cnt < k + L);
    end else if (c <= dend) begin
      e_busy = 1;
    end else if (c == dend + 1) begin
      e_done = 1;
    end else begin
      e_ready = 1;
    end
    t = $sformatf("L%0d c%0d", L, c);
    check({t, " ready"}, 32'(bus.ready_o), 32'(e_ready));
    check({t, " busy"},  32'(bus.busy_o),  32'(e_busy));
    check({t, " done"},  32'(bus.done_o),  32'(e_done));
    check({t, " ifmap_rd"}, 32'(bus.ifmap_rd_en_o), 32'(e_ird));
    check({t, " ifmap_addr"}, 32'(bus.ifmap_addr_o), e_iaddr);
    check({t, " ifmap_en"}, 32'(bus.ifmap_en_row_o), 32'(e_row));
    check({t, " weight_rd"}, 32'(bus.weight_rd_en_o), 32'(e_wrd));
    check({t, " weight_addr"}, 32'(bus.weight_addr_o), e_waddr);
    check({t, " weight_en"}, 32'(bus.weight_en_col_o), 32'(e_col));
    check({t, " psum_en"}, 32'(bus.psum_en_row_o), 32'(e_col));
  endtask

  // Runs one tile from a falling edge in IDLE. poke_at: cycle where a stray
  // start is raised. abort_at/abort_kind: 1 = clear_i, 2 = async reset.
  task automatic run_tile(input int L, input int poke_at, input int abort_at,
                          input int abort_kind);
    int total;
    total = L + 3 * PE + 1;
    bus.start_i = 1'b1;
    bus.len_i   = LW'(L);
    for (int c = 1; c <= total + 1; c++) begin
      @(negedge clk);
      bus.start_i = 1'b0;
      bus.clear_i = 1'b0;
      check_cycle(c, L);
      if (c == poke_at) begin
        bus.start_i = 1'b1;
        bus.len_i   = 8'd5;
      end
      if (c == abort_at && abort_kind == 1) begin
        bus.clear_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
          @(negedge clk);
          bus.clear_i = 1'b0;
          check_idle($sformatf("clear c%0d", c + 1 + i));
        end
        $display("tile L=%0d aborted by clear at cycle %0d", L, c);
        return;
      end
      if (c == abort_at && abort_kind == 2) begin
        rst_n = 1'b0;
        #1;
        check_idle($sformatf("async rst c%0d", c));
        @(negedge clk);
        check_idle("rst held");
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
          @(negedge clk);
          check_idle($sformatf("after rst %0d", i));
        end
        $display("tile L=%0d aborted by reset at cycle %0d", L, c);
        return;
      end
    end
    $display("tile L=%0d poke=%0d completed", L, poke_at);
  endtask

  initial begin
    bus.start_i = 1'b0;
    bus.clear_i = 1'b0;
    bus.len_i   = '0;
    repeat (2) @(negedge clk);
    check_idle("reset");
    // Release reset and request on the very first rising edge afterwards.
    rst_n = 1'b1;
    run_tile(16, 0, 0, 0);
    run_tile(1, 0, 0, 0);

    // start with len 0 is ignored
    bus.start_i = 1'b1;
    bus.len_i   = 8'd0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      bus.start_i = 1'b0;
      check_idle($sformatf("len0 %0d", i));
    end
    $display("start with len=0 ignored");

    // start together with clear in IDLE stays IDLE
    bus.start_i = 1'b1;
    bus.clear_i = 1'b1;
    bus.len_i   = 8'd8;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      bus.start_i = 1'b0;
      bus.clear_i = 1'b0;
      check_idle($sformatf("start+clear %0d", i));
    end
    $display("start with clear ignored");

    run_tile(16, 20, 0, 0);   // stray start during COMPUTE
    run_tile(16, 0, 20, 1);   // clear at cycle 20
    run_tile(16, 0, 0, 0);    // full tile after clear
    run_tile(16, 0, 30, 2);   // async reset at cycle 30
    run_tile(255, 0, 0, 0);   // maximum length

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end
endmodule
